// File: rtl/cpu_wb_arb_pkg.sv
// Shared definitions for the I-cache/D-cache Wishbone arbiter: FSM states,
// master indices and Wishbone B4 cycle/burst type constants.
package cpu_wb_arb_pkg;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbOwnM0 = 2'd1,
        ArbOwnM1 = 2'd2,
        ArbTmo   = 2'd3
    } arb_state_e;

    // Master indices: 0 is the I-cache, 1 is the D-cache.
    localparam logic MstI = 1'b0;
    localparam logic MstD = 1'b1;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiConst   = 3'b001;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEnd     = 3'b111;

    localparam logic [1:0] BteLinear = 2'b00;
    localparam logic [1:0] BteWrap4  = 2'b01;
    localparam logic [1:0] BteWrap8  = 2'b10;
    localparam logic [1:0] BteWrap16 = 2'b11;

    function automatic logic [1:0] gnt_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cpu_wb_arb_watchdog.sv
// Bus watchdog: counts cycles while INC is high, clears on CLR, and pulses
// TIMEOUT on the cycle the count reaches TIMEOUT_CYCLES-1.
module cpu_wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Firing on the increment into TIMEOUT_CYCLES-1 lets the owner enter the
    // timeout state on the same edge the count gets there.
    localparam logic [CntW-1:0] FireVal = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_o = inc_i & ~clr_i & (cnt_q == FireVal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_wb_arb.sv
// Two-master (I-cache, D-cache) to one-slave pipelined Wishbone B4 arbiter.
// Grants are held for a whole CYC; a watchdog turns a hung slave into ERR.
module cpu_wb_arb
    import cpu_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned OUTST_W        = 4
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,

    input  logic [31:0] M0_ADR_IN,
    input  logic        M0_CYC_IN,
    input  logic        M0_STB_IN,
    input  logic        M0_WE_IN,
    input  logic [3:0]  M0_SEL_IN,
    input  logic [2:0]  M0_CTI_IN,
    input  logic [1:0]  M0_BTE_IN,
    input  logic [31:0] M0_DAT_WR_IN,
    output logic        M0_STALL_OUT,
    output logic        M0_ACK_OUT,
    output logic        M0_ERR_OUT,
    output logic [31:0] M0_DAT_RD_OUT,

    input  logic [31:0] M1_ADR_IN,
    input  logic        M1_CYC_IN,
    input  logic        M1_STB_IN,
    input  logic        M1_WE_IN,
    input  logic [3:0]  M1_SEL_IN,
    input  logic [2:0]  M1_CTI_IN,
    input  logic [1:0]  M1_BTE_IN,
    input  logic [31:0] M1_DAT_WR_IN,
    output logic        M1_STALL_OUT,
    output logic        M1_ACK_OUT,
    output logic        M1_ERR_OUT,
    output logic [31:0] M1_DAT_RD_OUT,

    output logic [31:0] S_ADR_OUT,
    output logic        S_CYC_OUT,
    output logic        S_STB_OUT,
    output logic        S_WE_OUT,
    output logic [3:0]  S_SEL_OUT,
    output logic [2:0]  S_CTI_OUT,
    output logic [1:0]  S_BTE_OUT,
    output logic [31:0] S_DAT_WR_OUT,
    input  logic        S_ACK_IN,
    input  logic        S_STALL_IN,
    input  logic        S_ERR_IN,
    input  logic [31:0] S_DAT_RD_IN,

    output logic [1:0]  ARB_GNT_OUT
);

    arb_state_e         state_q;
    logic               last_gnt_q;
    logic               owner_q;
    logic               tmo_err_q;
    logic [1:0]         gnt_q;
    logic [OUTST_W-1:0] outst_q;

    logic own0, own1, own, tmo;
    logic full, owner_cyc, accept, resp;
    logic wd_clr, wd_inc, wd_timeout;

    assign own0      = (state_q == ArbOwnM0);
    assign own1      = (state_q == ArbOwnM1);
    assign own       = own0 | own1;
    assign tmo       = (state_q == ArbTmo);
    assign full      = &outst_q;
    assign owner_cyc = owner_q ? M1_CYC_IN : M0_CYC_IN;
    assign accept    = S_STB_OUT & ~S_STALL_IN;
    assign resp      = S_ACK_IN | S_ERR_IN;

    // Slave-side request mux. STB is gated while the beat counter is full so
    // the slave never accepts a beat the master was told is stalled.
    always_comb begin
        S_ADR_OUT    = '0;
        S_CYC_OUT    = 1'b0;
        S_STB_OUT    = 1'b0;
        S_WE_OUT     = 1'b0;
        S_SEL_OUT    = '0;
        S_CTI_OUT    = '0;
        S_BTE_OUT    = '0;
        S_DAT_WR_OUT = '0;
        unique case (state_q)
            ArbOwnM0: begin
                S_ADR_OUT    = M0_ADR_IN;
                S_CYC_OUT    = M0_CYC_IN;
                S_STB_OUT    = M0_STB_IN & ~full;
                S_WE_OUT     = M0_WE_IN;
                S_SEL_OUT    = M0_SEL_IN;
                S_CTI_OUT    = M0_CTI_IN;
                S_BTE_OUT    = M0_BTE_IN;
                S_DAT_WR_OUT = M0_DAT_WR_IN;
            end
            ArbOwnM1: begin
                S_ADR_OUT    = M1_ADR_IN;
                S_CYC_OUT    = M1_CYC_IN;
                S_STB_OUT    = M1_STB_IN & ~full;
                S_WE_OUT     = M1_WE_IN;
                S_SEL_OUT    = M1_SEL_IN;
                S_CTI_OUT    = M1_CTI_IN;
                S_BTE_OUT    = M1_BTE_IN;
                S_DAT_WR_OUT = M1_DAT_WR_IN;
            end
            default: ;
        endcase
    end

    // Master-side response routing; the timeout ERR comes from a registered pulse.
    assign M0_STALL_OUT  = own0 ? (S_STALL_IN | full) : 1'b1;
    assign M0_ACK_OUT    = own0 & S_ACK_IN;
    assign M0_ERR_OUT    = (own0 & S_ERR_IN) | (tmo & (owner_q == MstI) & tmo_err_q);
    assign M0_DAT_RD_OUT = own0 ? S_DAT_RD_IN : '0;

    assign M1_STALL_OUT  = own1 ? (S_STALL_IN | full) : 1'b1;
    assign M1_ACK_OUT    = own1 & S_ACK_IN;
    assign M1_ERR_OUT    = (own1 & S_ERR_IN) | (tmo & (owner_q == MstD) & tmo_err_q);
    assign M1_DAT_RD_OUT = own1 ? S_DAT_RD_IN : '0;

    assign ARB_GNT_OUT   = gnt_q;

    assign wd_clr = ~own | resp | (outst_q == '0);
    assign wd_inc = ~wd_clr;

    cpu_wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (CLK),
        .rst_ni   (RST_ASYNC_N),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .timeout_o(wd_timeout)
    );

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q    <= ArbIdle;
            last_gnt_q <= MstD;
            owner_q    <= MstI;
            tmo_err_q  <= 1'b0;
            gnt_q      <= '0;
            outst_q    <= '0;
        end else begin
            tmo_err_q <= 1'b0;
            unique case (state_q)
                ArbIdle: begin
                    outst_q <= '0;
                    if (M0_CYC_IN && (!M1_CYC_IN || last_gnt_q == MstD)) begin
                        state_q <= ArbOwnM0;
                        owner_q <= MstI;
                        gnt_q   <= gnt_onehot(MstI);
                    end else if (M1_CYC_IN) begin
                        state_q <= ArbOwnM1;
                        owner_q <= MstD;
                        gnt_q   <= gnt_onehot(MstD);
                    end
                end
                ArbOwnM0, ArbOwnM1: begin
                    // Release wins over timeout: a dropped CYC ends the tenure cleanly.
                    if (!owner_cyc) begin
                        state_q    <= ArbIdle;
                        last_gnt_q <= owner_q;
                        gnt_q      <= '0;
                        outst_q    <= '0;
                    end else if (wd_timeout) begin
                        state_q   <= ArbTmo;
                        tmo_err_q <= 1'b1;
                        outst_q   <= '0;
                    end else if (accept && !resp) begin
                        outst_q <= outst_q + 1'b1;
                    end else if (!accept && resp && outst_q != '0) begin
                        outst_q <= outst_q - 1'b1;
                    end
                end
                ArbTmo: begin
                    outst_q <= '0;
                    if (!owner_cyc) begin
                        state_q    <= ArbIdle;
                        last_gnt_q <= owner_q;
                        gnt_q      <= '0;
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_wb_arb.sv
// Scoreboard bench for cpu_wb_arb: two autonomous burst masters, a pipelined
// slave model, and expected read data queued per master at beat acceptance.
module tb_cpu_wb_arb;
    import cpu_wb_arb_pkg::*;

    localparam int unsigned Tmo = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cyc, stb, we;
    logic [31:0] adr [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel [2];
    logic [2:0]  cti [2];
    logic [1:0]  bte [2];
    logic [1:0]  stall_o, ack_o, err_o;
    logic [31:0] rdat0, rdat1;
    logic [31:0] s_adr, s_dat_wr, s_dat_rd;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall, s_err;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic [1:0]  gnt;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    bit active [2];
    bit hold_cyc [2];
    int want [2], sent [2], done [2], ack_cnt [2], err_cnt [2];
    int acc_cyc [2], err_cyc [2], outst_b [2], outst_max [2];
    bit acc_this [2], resp_this [2];
    logic [31:0] base [2];
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] slv_q [$];
    bit slave_hold = 1'b0;
    bit stall_chk = 1'b0;
    int stall_beat = -1;
    int stall_left = 0;

    always #5 clk = ~clk;

    cpu_wb_arb #(
        .TIMEOUT_CYCLES(Tmo),
        .OUTST_W       (4)
    ) dut (
        .CLK          (clk),
        .RST_ASYNC_N  (rst_n),
        .M0_ADR_IN    (adr[0]),
        .M0_CYC_IN    (cyc[0]),
        .M0_STB_IN    (stb[0]),
        .M0_WE_IN     (we[0]),
        .M0_SEL_IN    (sel[0]),
        .M0_CTI_IN    (cti[0]),
        .M0_BTE_IN    (bte[0]),
        .M0_DAT_WR_IN (wdat[0]),
        .M0_STALL_OUT (stall_o[0]),
        .M0_ACK_OUT   (ack_o[0]),
        .M0_ERR_OUT   (err_o[0]),
        .M0_DAT_RD_OUT(rdat0),
        .M1_ADR_IN    (adr[1]),
        .M1_CYC_IN    (cyc[1]),
        .M1_STB_IN    (stb[1]),
        .M1_WE_IN     (we[1]),
        .M1_SEL_IN    (sel[1]),
        .M1_CTI_IN    (cti[1]),
        .M1_BTE_IN    (bte[1]),
        .M1_DAT_WR_IN (wdat[1]),
        .M1_STALL_OUT (stall_o[1]),
        .M1_ACK_OUT   (ack_o[1]),
        .M1_ERR_OUT   (err_o[1]),
        .M1_DAT_RD_OUT(rdat1),
        .S_ADR_OUT    (s_adr),
        .S_CYC_OUT    (s_cyc),
        .S_STB_OUT    (s_stb),
        .S_WE_OUT     (s_we),
        .S_SEL_OUT    (s_sel),
        .S_CTI_OUT    (s_cti),
        .S_BTE_OUT    (s_bte),
        .S_DAT_WR_OUT (s_dat_wr),
        .S_ACK_IN     (s_ack),
        .S_STALL_IN   (s_stall),
        .S_ERR_IN     (s_err),
        .S_DAT_RD_IN  (s_dat_rd),
        .ARB_GNT_OUT  (gnt)
    );

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic start(input int m, input logic [31:0] b, input int n, input logic w);
        base[m]      = b;
        want[m]      = n;
        sent[m]      = 0;
        done[m]      = 0;
        ack_cnt[m]   = 0;
        err_cnt[m]   = 0;
        outst_b[m]   = 0;
        outst_max[m] = 0;
        active[m]    = 1'b1;
        cyc[m]       = 1'b1;
        stb[m]       = 1'b1;
        we[m]        = w;
        adr[m]       = b;
        wdat[m]      = b ^ 32'h1234_5678;
        sel[m]       = 4'hF;
        cti[m]       = (n == 1) ? CtiEnd : CtiIncr;
        bte[m]       = BteLinear;
    endtask

    // One clock: sample/score before the edge, then advance slave and masters.
    task automatic tick();
        logic [31:0] d;
        logic [31:0] e;
        #2;
        if (s_cyc && s_stb && !s_stall) slv_q.push_back(s_adr);
        for (int m = 0; m < 2; m++) begin
            d = (m == 0) ? rdat0 : rdat1;
            acc_this[m]  = 1'b0;
            resp_this[m] = 1'b0;
            if (!gnt[m]) begin
                check_eq("nonowner_stall", {31'd0, stall_o[m]}, 32'd1);
                check_eq("nonowner_ack", {31'd0, ack_o[m]}, 32'd0);
                check_eq("nonowner_dat", d, 32'd0);
            end
            if (cyc[m] && stb[m] && !stall_o[m]) begin
                acc_this[m] = 1'b1;
                acc_cyc[m]  = cyc_n;
                if (m == 0) exp_q0.push_back(rd_model(adr[m]));
                else        exp_q1.push_back(rd_model(adr[m]));
                check_eq("s_adr", s_adr, adr[m]);
                check_eq("s_cti", {29'd0, s_cti}, {29'd0, cti[m]});
                check_eq("s_we_sel", {27'd0, s_we, s_sel}, {27'd0, we[m], sel[m]});
                if (we[m]) check_eq("s_dat_wr", s_dat_wr, wdat[m]);
                outst_b[m]++;
            end
            if (ack_o[m]) begin
                ack_cnt[m]++;
                resp_this[m] = 1'b1;
                if (((m == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                    check_eq("spurious_ack", {31'd0, ack_o[m]}, 32'd0);
                end else begin
                    e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check_eq("rdata", d, e);
                end
            end
            if (err_o[m]) begin
                err_cnt[m]++;
                err_cyc[m]   = cyc_n;
                resp_this[m] = 1'b1;
                if (m == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
                if (m == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
            end
            if (resp_this[m] && outst_b[m] > 0) outst_b[m]--;
            if (outst_b[m] > outst_max[m]) outst_max[m] = outst_b[m];
        end
        if (stall_chk && s_stall && gnt[1]) begin
            check_eq("t4_m1_stall", {31'd0, stall_o[1]}, 32'd1);
            check_eq("t4_adr_held", s_adr, base[1] + 32'(4 * sent[1]));
        end
        @(posedge clk);
        #1;
        cyc_n++;
        s_ack    = 1'b0;
        s_dat_rd = '0;
        if (!slave_hold && slv_q.size() > 0) begin
            s_ack    = 1'b1;
            s_dat_rd = rd_model(slv_q.pop_front());
        end
        for (int m = 0; m < 2; m++) begin
            if (active[m]) begin
                if (acc_this[m]) sent[m]++;
                if (resp_this[m]) done[m]++;
                if (done[m] >= want[m]) begin
                    stb[m] = 1'b0;
                    if (!hold_cyc[m]) begin
                        cyc[m]    = 1'b0;
                        active[m] = 1'b0;
                    end
                end else begin
                    stb[m] = (sent[m] < want[m]);
                    adr[m] = base[m] + 32'(4 * sent[m]);
                    cti[m] = (sent[m] == want[m] - 1) ? CtiEnd : CtiIncr;
                end
            end
        end
        s_stall = 1'b0;
        if (stall_left > 0 && active[1] && sent[1] == stall_beat) begin
            s_stall = 1'b1;
            stall_left--;
        end
    endtask

    task automatic wait_done(input int m, input string tag);
        int n = 0;
        while (active[m] && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, {31'd0, active[m]}, 32'd0);
    endtask

    task automatic idle2();
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_scyc_stb"}, {30'd0, s_cyc, s_stb}, 32'd0);
        check_eq({tag, "_stall"}, {30'd0, stall_o}, 32'd3);
        check_eq({tag, "_ack_err"}, {28'd0, ack_o, err_o}, 32'd0);
        check_eq({tag, "_gnt"}, {30'd0, gnt}, 32'd0);
        check_eq({tag, "_rdat"}, rdat0 | rdat1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0;
        for (int m = 0; m < 2; m++) begin
            adr[m] = '0; wdat[m] = '0; sel[m] = '0; cti[m] = '0; bte[m] = '0;
            active[m] = 1'b0; hold_cyc[m] = 1'b0;
        end
        s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0; s_dat_rd = '0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle2();

        // Tie after reset: M0 first, one idle cycle, then M1; repeat alternates.
        start(0, 32'h0000_1000, 2, 1'b0);
        start(1, 32'h0000_2000, 2, 1'b0);
        tick();
        check_eq("t2_gnt_m0", {30'd0, gnt}, 32'd1);
        wait_done(0, "t2_m0_done");
        tick();
        check_eq("t2_gap_idle", {30'd0, gnt}, 32'd0);
        tick();
        check_eq("t2_gnt_m1", {30'd0, gnt}, 32'd2);
        wait_done(1, "t2_m1_done");
        idle2();
        start(0, 32'h0000_1100, 1, 1'b0);
        start(1, 32'h0000_2100, 1, 1'b0);
        tick();
        check_eq("t2_regnt_m0", {30'd0, gnt}, 32'd1);
        wait_done(0, "t2_m0_done2");
        wait_done(1, "t2_m1_done2");
        idle2();

        // M0 4-beat incrementing burst, slave never stalls.
        start(0, 32'h0000_1000, 4, 1'b0);
        tick();
        check_eq("t1_gnt", {30'd0, gnt}, 32'd1);
        wait_done(0, "t1_done");
        check_eq("t1_acks", 32'(ack_cnt[0]), 32'd4);
        check_eq("t1_errs", 32'(err_cnt[0]), 32'd0);
        idle2();

        // M1 requests mid M0 burst; it waits until two cycles after M0 drops CYC.
        start(0, 32'h0000_1000, 8, 1'b0);
        tick();
        tick();
        tick();
        start(1, 32'h0000_2000, 2, 1'b1);
        wait_done(0, "t3_m0_done");
        tick();
        check_eq("t3_idle_m1_stall", {31'd0, stall_o[1]}, 32'd1);
        tick();
        check_eq("t3_gnt_m1", {30'd0, gnt}, 32'd2);
        check_eq("t3_m1_stall", {31'd0, stall_o[1]}, 32'd0);
        check_eq("t3_s_adr", s_adr, 32'h0000_2000);
        wait_done(1, "t3_m1_done");
        check_eq("t3_m1_acks", 32'(ack_cnt[1]), 32'd2);
        idle2();

        // Slave stalls 3 cycles on the second beat of an M1 read burst.
        stall_beat = 1;
        stall_left = 3;
        stall_chk  = 1'b1;
        start(1, 32'h0000_3000, 4, 1'b0);
        wait_done(1, "t4_done");
        stall_chk = 1'b0;
        check_eq("t4_acks", 32'(ack_cnt[1]), 32'd4);
        check_eq("t4_outst_le2", {31'd0, outst_max[1] <= 2}, 32'd1);
        check_eq("t4_stall_used", 32'(stall_left), 32'd0);
        idle2();

        // Hung slave: watchdog ERR, late ACK ignored, release to idle.
        slave_hold  = 1'b1;
        hold_cyc[0] = 1'b1;
        start(0, 32'h0000_4000, 1, 1'b0);
        n = 0;
        while (err_cnt[0] == 0 && n < 60) begin
            tick();
            n++;
        end
        check_eq("t5_err_seen", 32'(err_cnt[0]), 32'd1);
        check_eq("t5_err_latency", 32'(err_cyc[0] - acc_cyc[0]), 32'(Tmo));
        check_eq("t5_tmo_scyc_stb", {30'd0, s_cyc, s_stb}, 32'd0);
        check_eq("t5_err_pulse_end", {31'd0, err_o[0]}, 32'd0);
        check_eq("t5_tmo_stall", {31'd0, stall_o[0]}, 32'd1);
        s_ack    = 1'b1;
        s_dat_rd = 32'h0000_0BAD;
        #1;
        check_eq("t5_late_ack", {31'd0, ack_o[0]}, 32'd0);
        check_eq("t5_late_dat", rdat0, 32'd0);
        tick();
        cyc[0]      = 1'b0;
        active[0]   = 1'b0;
        hold_cyc[0] = 1'b0;
        tick();
        check_eq("t5_idle", {30'd0, gnt}, 32'd0);
        check_eq("t5_err_once", 32'(err_cnt[0]), 32'd1);
        slave_hold = 1'b0;
        slv_q.delete();
        idle2();

        // Asynchronous reset mid M1 burst, between clock edges.
        start(1, 32'h0000_5000, 8, 1'b0);
        tick();
        tick();
        tick();
        check_eq("t6_busy", {31'd0, s_cyc}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        for (int m = 0; m < 2; m++) begin
            active[m] = 1'b0;
            cyc[m]    = 1'b0;
            stb[m]    = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
        slv_q.delete();
        s_ack = 1'b0;
        s_dat_rd = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_held");
        rst_n = 1'b1;
        start(0, 32'h0000_6000, 1, 1'b0);
        start(1, 32'h0000_7000, 1, 1'b0);
        tick();
        check_eq("t6_tie_m0", {30'd0, gnt}, 32'd1);
        wait_done(0, "t6_m0_done");
        wait_done(1, "t6_m1_done");
        idle2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
